// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a centred 640x360 letterbox window.
`timescale 1ns/1ps
package vga_timing_pkg;

    // 640x480@60 raster
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // 640x360 letterbox, inclusive bounds
    localparam int DEF_WIN_X0 = 0;
    localparam int DEF_WIN_X1 = 639;
    localparam int DEF_WIN_Y0 = 60;
    localparam int DEF_WIN_Y1 = 419;

    // Range decode of one axis, evaluated on the next-state count
    typedef struct packed {
        logic sync;  // inside the sync pulse region (raw, before polarity)
        logic vis;   // inside the visible area
        logic win;   // inside the letterbox window
        logic pre;   // before the letterbox window start
    } axis_dec_t;

    // Bits needed to hold 0..value-1 (at least one bit)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrap counter with enable, restart and wrap pulse, plus
// sync / visible / window range decode of the next-state count so the
// parent can register outputs that line up with the counter.
`timescale 1ns/1ps
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL   = DEF_H_TOTAL,
    parameter int ACTIVE  = DEF_H_ACTIVE,
    parameter int SYNC_LO = DEF_H_ACTIVE + DEF_H_FP,
    parameter int SYNC_HI = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC,
    parameter int WIN_LO  = DEF_WIN_X0,
    parameter int WIN_HI  = DEF_WIN_X1,
    parameter int W       = clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         restart_i,
    output logic [W-1:0] cnt_d_o,
    output logic         wrap_o,
    output axis_dec_t    dec_d_o
);
    localparam int            WP        = W + 1;
    localparam logic [W-1:0]  LAST      = W'(TOTAL - 1);
    localparam logic [W:0]    ACTIVE_X  = WP'(ACTIVE);
    localparam logic [W:0]    SYNC_LO_X = WP'(SYNC_LO);
    localparam logic [W:0]    SYNC_HI_X = WP'(SYNC_HI);
    localparam logic [W:0]    WIN_HI_X  = WP'(WIN_HI);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   cnt_x;
    logic         pre_d;

    // Next count: restart wins, otherwise advance on enable and wrap at TOTAL-1
    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o = cnt_d;
    assign cnt_x   = {1'b0, cnt_d};

    // A window starting at 0 has no "before" region
    if (WIN_LO == 0) begin : g_pre_none
        assign pre_d = 1'b0;
    end else begin : g_pre_cmp
        assign pre_d = cnt_x < WP'(WIN_LO);
    end

    // Range decode of the next-state count
    always_comb begin
        dec_d_o      = '0;
        dec_d_o.sync = (cnt_x >= SYNC_LO_X) && (cnt_x < SYNC_HI_X);
        dec_d_o.vis  = cnt_x < ACTIVE_X;
        dec_d_o.pre  = pre_d;
        dec_d_o.win  = !pre_d && (cnt_x <= WIN_HI_X);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a letterbox window. Every output is a
// register loaded from the next-state h/v decode, so outputs always describe
// the current counter position with no combinational path from the inputs.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int WIN_X0   = DEF_WIN_X0,
    parameter int WIN_X1   = DEF_WIN_X1,
    parameter int WIN_Y0   = DEF_WIN_Y0,
    parameter int WIN_Y1   = DEF_WIN_Y1,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int FCW      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_stb,
    input  logic           i_restart,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_blanking,
    output logic           o_active,
    output logic [XW-1:0]  o_x,
    output logic [YW-1:0]  o_y,
    output logic           o_line_start,
    output logic           o_animate,
    output logic           o_screenend,
    output logic [FCW-1:0] o_frame_cnt
);
    localparam int              H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int              V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int              HW      = clog2(H_TOTAL);
    localparam int              VW      = clog2(V_TOTAL);
    localparam int              VWP     = VW + 1;
    localparam logic [VW:0]     ANIM_V  = VWP'(WIN_Y1 + 1);
    localparam logic [XW-1:0]   X_MAX   = XW'(WIN_X1 - WIN_X0);
    localparam logic [YW-1:0]   Y_MAX   = YW'(WIN_Y1 - WIN_Y0);
    localparam logic            ACT_RST = (WIN_X0 == 0) && (WIN_Y0 == 0);

    if (WIN_X1 >= H_ACTIVE || WIN_Y1 >= V_ACTIVE || WIN_X0 > WIN_X1 ||
        WIN_Y0 > WIN_Y1 || H_TOTAL >= 2048) begin : g_bad_params
        $fatal(1, "vga_timing_gen: window outside active area or H_TOTAL too large");
    end

    logic [HW-1:0]  h_d;
    logic [VW-1:0]  v_d;
    logic           h_wrap, v_wrap;
    axis_dec_t      h_dec, v_dec;

    logic           hs_q, vs_q, blank_q, act_q;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           ls_q, anim_q, se_q, anim_d;
    logic [FCW-1:0] fc_q, fc_d;

    vga_axis_counter #(
        .TOTAL   (H_TOTAL),
        .ACTIVE  (H_ACTIVE),
        .SYNC_LO (H_ACTIVE + H_FP),
        .SYNC_HI (H_ACTIVE + H_FP + H_SYNC),
        .WIN_LO  (WIN_X0),
        .WIN_HI  (WIN_X1),
        .W       (HW)
    ) u_h (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .en_i      (i_pix_stb),
        .restart_i (i_restart),
        .cnt_d_o   (h_d),
        .wrap_o    (h_wrap),
        .dec_d_o   (h_dec)
    );

    vga_axis_counter #(
        .TOTAL   (V_TOTAL),
        .ACTIVE  (V_ACTIVE),
        .SYNC_LO (V_ACTIVE + V_FP),
        .SYNC_HI (V_ACTIVE + V_FP + V_SYNC),
        .WIN_LO  (WIN_Y0),
        .WIN_HI  (WIN_Y1),
        .W       (VW)
    ) u_v (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .en_i      (h_wrap),
        .restart_i (i_restart),
        .cnt_d_o   (v_d),
        .wrap_o    (v_wrap),
        .dec_d_o   (v_dec)
    );

    // Window-relative coordinates clamped to the window edges, frame count and
    // end-of-window pulse (the h wrap that moves v from WIN_Y1 to WIN_Y1+1)
    always_comb begin
        if (h_dec.pre) begin
            x_d = '0;
        end else if (h_dec.win) begin
            x_d = XW'(h_d - HW'(WIN_X0));
        end else begin
            x_d = X_MAX;
        end
        if (v_dec.pre) begin
            y_d = '0;
        end else if (v_dec.win) begin
            y_d = YW'(v_d - VW'(WIN_Y0));
        end else begin
            y_d = Y_MAX;
        end
        anim_d = h_wrap && ({1'b0, v_d} == ANIM_V);
        fc_d   = fc_q + FCW'(v_wrap);
    end

    // Output registers, reset to the h=0,v=0 decode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            act_q   <= ACT_RST;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            anim_q  <= 1'b0;
            se_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            hs_q    <= h_dec.sync ? HS_POL : ~HS_POL;
            vs_q    <= v_dec.sync ? VS_POL : ~VS_POL;
            blank_q <= !(h_dec.vis && v_dec.vis);
            act_q   <= h_dec.win && v_dec.win;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= h_wrap;
            anim_q  <= anim_d;
            se_q    <= v_wrap;
            fc_q    <= fc_d;
        end
    end

    assign o_hs         = hs_q;
    assign o_vs         = vs_q;
    assign o_blanking   = blank_q;
    assign o_active     = act_q;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_line_start = ls_q;
    assign o_animate    = anim_q;
    assign o_screenend  = se_q;
    assign o_frame_cnt  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 24x17 raster with a 12x7 window.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
    localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
    localparam int X0 = 2, X1 = 13, Y0 = 3, Y1 = 9;
    localparam int XW = 5, YW = 4, FCW = 2;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           blank;
        logic           act;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic           ls;
        logic           anim;
        logic           se;
        logic [FCW-1:0] fc;
    } exp_t;

    typedef struct {
        int             h;
        int             v;
        logic           hs;
        logic           vs;
        logic           blank;
        logic           act;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
    } tbl_t;

    localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b0, blank: 1'b0, act: 1'b0,
                                 x: '0, y: '0, ls: 1'b0, anim: 1'b0, se: 1'b0, fc: '0};

    logic           clk = 1'b0;
    logic           rst_n, pix_stb, restart;
    logic           o_hs, o_vs, o_blanking, o_active, o_line_start, o_animate, o_screenend;
    logic [XW-1:0]  o_x;
    logic [YW-1:0]  o_y;
    logic [FCW-1:0] o_frame_cnt;

    int   checks = 0;
    int   errors = 0;
    int   mh, mv, mfc;
    exp_t sbq[$];
    tbl_t tbl[12];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL),
        .WIN_X0(X0), .WIN_X1(X1), .WIN_Y0(Y0), .WIN_Y1(Y1),
        .XW(XW), .YW(YW), .FCW(FCW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_restart(restart),
        .o_hs(o_hs), .o_vs(o_vs), .o_blanking(o_blanking), .o_active(o_active),
        .o_x(o_x), .o_y(o_y), .o_line_start(o_line_start), .o_animate(o_animate),
        .o_screenend(o_screenend), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic exp_t dut_now();
        exp_t d;
        d = '{hs: o_hs, vs: o_vs, blank: o_blanking, act: o_active, x: o_x, y: o_y,
              ls: o_line_start, anim: o_animate, se: o_screenend, fc: o_frame_cnt};
        return d;
    endfunction

    // Expected outputs for the model position mh/mv
    function automatic exp_t expect_at(input logic ls, input logic an, input logic se);
        exp_t e;
        e.hs    = (mh >= HA + HFP && mh < HA + HFP + HSY) ? HPOL : ~HPOL;
        e.vs    = (mv >= VA + VFP && mv < VA + VFP + VSY) ? VPOL : ~VPOL;
        e.blank = !(mh < HA && mv < VA);
        e.act   = (mh >= X0 && mh <= X1 && mv >= Y0 && mv <= Y1);
        e.x     = (mh < X0) ? '0 : (mh > X1) ? XW'(X1 - X0) : XW'(mh - X0);
        e.y     = (mv < Y0) ? '0 : (mv > Y1) ? YW'(Y1 - Y0) : YW'(mv - Y0);
        e.ls    = ls;
        e.anim  = an;
        e.se    = se;
        e.fc    = FCW'(mfc);
        return e;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mfc = 0;
        sbq.delete();
    endtask

    task automatic model_step(input logic stb, input logic rs);
        logic ls, an, se;
        ls = 1'b0; an = 1'b0; se = 1'b0;
        if (rs) begin
            mh = 0;
            mv = 0;
        end else if (stb) begin
            if (mh == HT - 1) begin
                mh = 0;
                ls = 1'b1;
                if (mv == Y1) an = 1'b1;
                if (mv == VT - 1) begin
                    mv = 0;
                    se = 1'b1;
                    mfc = (mfc + 1) % (1 << FCW);
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        sbq.push_back(expect_at(ls, an, se));
    endtask

    // Drive one clock of stimulus, then compare against the scoreboard entry
    task automatic tick(input logic stb, input logic rs);
        exp_t want;
        pix_stb = stb;
        restart = rs;
        model_step(stb, rs);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, expected entry missing");
        end else begin
            want = sbq.pop_front();
            check($sformatf("cycle h=%0d v=%0d", mh, mv), 32'(dut_now()), 32'(want));
        end
        pix_stb = 1'b0;
        restart = 1'b0;
    endtask

    task automatic goto(input int h, input int v);
        tick(1'b0, 1'b1);
        for (int i = 0; i < v * HT + h; i++) tick(1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int se_n, ls_n, an_n, an_at, hs_low, hs_first;

        //          h   v  hs    vs    blk   act   x      y
        tbl[0]  = '{0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  4'd0};
        tbl[1]  = '{2,  3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  4'd0};
        tbl[2]  = '{13, 9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 4'd6};
        tbl[3]  = '{14, 9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 4'd6};
        tbl[4]  = '{0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  4'd6};
        tbl[5]  = '{16, 5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd11, 4'd2};
        tbl[6]  = '{18, 5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 4'd2};
        tbl[7]  = '{20, 5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 4'd2};
        tbl[8]  = '{21, 5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd11, 4'd2};
        tbl[9]  = '{5, 13, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3,  4'd6};
        tbl[10] = '{5, 15, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3,  4'd6};
        tbl[11] = '{1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  4'd0};

        rst_n = 1'b0;
        pix_stb = 1'b0;
        restart = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset values", 32'(dut_now()), 32'(RST_EXP));
        rst_n = 1'b1;

        // Raster positions against hand-derived decode
        for (int i = 0; i < 12; i++) begin
            goto(tbl[i].h, tbl[i].v);
            check($sformatf("tbl%0d h=%0d v=%0d", i, tbl[i].h, tbl[i].v),
                  32'({o_hs, o_vs, o_blanking, o_active, o_x, o_y}),
                  32'({tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].act, tbl[i].x, tbl[i].y}));
        end

        // Five frames with a strobe every cycle
        goto(0, 0);
        se_n = 0; ls_n = 0; an_n = 0; hs_low = 0; hs_first = -1;
        for (int f = 1; f <= 5; f++) begin
            for (int k = 0; k < HT * VT; k++) begin
                tick(1'b1, 1'b0);
                if (o_screenend) se_n++;
                if (o_line_start) ls_n++;
                if (o_animate) an_n++;
                if (f == 1 && k < HT && o_hs == HPOL) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = (k + 1) % HT;
                end
            end
            if (f == 3) check("frame_cnt after 3 frames", 32'(o_frame_cnt), 3);
        end
        check("hsync low cycles per line", hs_low, HSY);
        check("hsync first low h", hs_first, HA + HFP);
        check("screenend count 5 frames", se_n, 5);
        check("line_start count 5 frames", ls_n, 5 * VT);
        check("animate count 5 frames", an_n, 5);
        check("frame_cnt wrapped after 5 frames", 32'(o_frame_cnt), 1);

        // One frame with a strobe every fourth clock
        goto(0, 0);
        ls_n = 0; an_n = 0; an_at = -1; se_n = 0;
        for (int s = 1; s <= HT * VT; s++) begin
            tick(1'b1, 1'b0);
            if (o_line_start) ls_n++;
            if (o_animate) begin
                an_n++;
                an_at = s;
            end
            if (o_screenend) se_n++;
            for (int q = 0; q < 3; q++) begin
                tick(1'b0, 1'b0);
                if (o_line_start) ls_n++;
                if (o_animate) an_n++;
                if (o_screenend) se_n++;
            end
        end
        check("slow stb line_start high cycles", ls_n, VT);
        check("slow stb animate count", an_n, 1);
        check("slow stb animate strobe index", an_at, (Y1 + 1) * HT);
        check("slow stb screenend count", se_n, 1);
        check("slow stb frame_cnt", 32'(o_frame_cnt), 2);

        // Restart together with a strobe that would otherwise end the frame
        goto(HT - 1, VT - 1);
        tick(1'b1, 1'b1);
        check("restart+stb at frame end",
              32'({o_active, o_x, o_y, o_line_start, o_animate, o_screenend, o_frame_cnt}),
              32'({1'b0, 5'd0, 4'd0, 3'b000, 2'd2}));

        // Asynchronous reset in the middle of a line
        goto(7, 4);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset before next edge", 32'(dut_now()), 32'(RST_EXP));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset held", 32'(dut_now()), 32'(RST_EXP));
        rst_n = 1'b1;
        for (int i = 0; i < Y0 * HT + X0; i++) tick(1'b1, 1'b0);
        check("window start after reset release",
              32'({o_active, o_x, o_y, o_frame_cnt}), 32'({1'b1, 5'd0, 4'd0, 2'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
